// File: rtl/stream_mux_pkg.sv
// Definitions shared by the transmit multiplexer and the receive demultiplexer:
// mode encodings, the stream-count helper, link state and default widths.
package stream_mux_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 32;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_1    = 2'b01;
    localparam logic [1:0] MODE_2    = 2'b10;
    localparam logic [1:0] MODE_3    = 2'b11;

    typedef enum logic {
        UNSYNC = 1'b0,
        LOCKED = 1'b1
    } link_state_t;

    // Number of round-robin streams carried in a given mode (0 when idle).
    function automatic logic [1:0] streams_for_mode(input logic [1:0] mode);
        logic [1:0] k;
        case (mode)
            MODE_1:  k = 2'd1;
            MODE_2:  k = 2'd2;
            MODE_3:  k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Tracks the position inside the round-robin frame: symbol count within the
// current slot and the slot index. force_zero lets the caller treat the
// current symbol as the first symbol of slot 0 (frame realignment).
module slot_timer
    import stream_mux_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             clear,
    input  logic             force_zero,
    input  logic [CNT_W-1:0] len,
    input  logic [1:0]       streams,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       slot,
    output logic             last_in_slot
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] base_count;
    logic [1:0]       base_slot;
    logic [2:0]       slot_inc;
    logic [1:0]       next_slot;

    // Position the current symbol is counted at; a greater-or-equal compare so
    // a slot shortened mid-flight ends right away instead of wrapping around.
    always_comb begin
        base_count   = force_zero ? '0 : count;
        base_slot    = force_zero ? 2'd0 : slot;
        slot_inc     = {1'b0, base_slot} + 3'd1;
        next_slot    = (slot_inc >= {1'b0, streams}) ? 2'd0 : slot_inc[1:0];
        last_in_slot = (base_count >= (len - ONE));
    end

    // Step the position once per accepted symbol; clear wins over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            slot  <= 2'd0;
        end else if (clear) begin
            count <= '0;
            slot  <= 2'd0;
        end else if (advance) begin
            if (last_in_slot) begin
                count <= '0;
                slot  <= next_slot;
            end else begin
                count <= base_count + ONE;
                slot  <= base_slot;
            end
        end
    end

endmodule

// File: rtl/stream_demultiplexer.sv
// Receive-side demultiplexer: splits the multiplexed symbol stream back into
// up to three streams by slot position, aligning on frame_sync.
module stream_demultiplexer
    import stream_mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              symbol_en,
    input  logic [CNT_W-1:0]  switch_clock_cycles,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] multiplexed_data,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] ds1_out,
    output logic [DATA_W-1:0] ds2_out,
    output logic [DATA_W-1:0] ds3_out,
    output logic              ds1_valid,
    output logic              ds2_valid,
    output logic              ds3_valid,
    output logic [1:0]        slot,
    output logic              locked,
    output logic              sync_err
);

    link_state_t      state;
    logic [1:0]       mode_q;
    logic [1:0]       streams;
    logic [CNT_W-1:0] slot_len;
    logic [CNT_W-1:0] count;
    logic             mode_change;
    logic             start;
    logic             run;
    logic             advance;
    logic             force_zero;
    logic [1:0]       cap_slot;
    logic             misaligned;
    logic             last_in_slot_unused;

    // Decode which symbol is accepted this cycle and where it belongs.
    always_comb begin
        streams     = streams_for_mode(mode);
        slot_len    = (switch_clock_cycles == '0) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                                  : switch_clock_cycles;
        mode_change = (mode != mode_q);
        start       = (state == UNSYNC) && symbol_en && frame_sync &&
                      (mode != MODE_IDLE) && !mode_change;
        run         = (state == LOCKED) && symbol_en && !mode_change;
        advance     = start || run;
        force_zero  = start || (run && frame_sync);
        cap_slot    = force_zero ? 2'd0 : slot;
        misaligned  = (slot != 2'd0) || (count != '0);
    end

    slot_timer #(
        .CNT_W(CNT_W)
    ) u_slot_timer (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .clear       (mode_change),
        .force_zero  (force_zero),
        .len         (slot_len),
        .streams     (streams),
        .count       (count),
        .slot        (slot),
        .last_in_slot(last_in_slot_unused)
    );

    // Track the previous mode so any change forces a fresh alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_IDLE;
        end else begin
            mode_q <= mode;
        end
    end

    // Link FSM plus capture registers and one-cycle valid / error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UNSYNC;
            ds1_out   <= '0;
            ds2_out   <= '0;
            ds3_out   <= '0;
            ds1_valid <= 1'b0;
            ds2_valid <= 1'b0;
            ds3_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            ds1_valid <= 1'b0;
            ds2_valid <= 1'b0;
            ds3_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (mode_change) begin
                state <= UNSYNC;
            end else if (start) begin
                state     <= LOCKED;
                ds1_out   <= multiplexed_data;
                ds1_valid <= 1'b1;
            end else if (run) begin
                sync_err <= frame_sync && misaligned;
                case (cap_slot)
                    2'd0: begin
                        ds1_out   <= multiplexed_data;
                        ds1_valid <= 1'b1;
                    end
                    2'd1: begin
                        ds2_out   <= multiplexed_data;
                        ds2_valid <= 1'b1;
                    end
                    2'd2: begin
                        ds3_out   <= multiplexed_data;
                        ds3_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Self-checking bench for stream_demultiplexer: directed scenarios plus a
// randomized run, all compared against a frame-position reference model.
module tb_stream_demultiplexer;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              symbol_en;
    logic              frame_sync;
    logic [CNT_W-1:0]  switch_clock_cycles;
    logic [1:0]        mode;
    logic [DATA_W-1:0] multiplexed_data;
    logic [DATA_W-1:0] ds1_out;
    logic [DATA_W-1:0] ds2_out;
    logic [DATA_W-1:0] ds3_out;
    logic              ds1_valid;
    logic              ds2_valid;
    logic              ds3_valid;
    logic [1:0]        slot;
    logic              locked;
    logic              sync_err;

    // reference model state
    logic [DATA_W-1:0] m_ds [3];
    bit                m_valid [3];
    int                m_slot;
    longint            m_cnt;
    bit                m_locked;
    bit                m_err;
    logic [1:0]        m_mode_q;

    int n_cmp = 0;
    int n_bad = 0;

    stream_demultiplexer #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .symbol_en          (symbol_en),
        .switch_clock_cycles(switch_clock_cycles),
        .mode               (mode),
        .multiplexed_data   (multiplexed_data),
        .frame_sync         (frame_sync),
        .ds1_out            (ds1_out),
        .ds2_out            (ds2_out),
        .ds3_out            (ds3_out),
        .ds1_valid          (ds1_valid),
        .ds2_valid          (ds2_valid),
        .ds3_valid          (ds3_valid),
        .slot               (slot),
        .locked             (locked),
        .sync_err           (sync_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ds[i]    = '0;
            m_valid[i] = 1'b0;
        end
        m_slot   = 0;
        m_cnt    = 0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_mode_q = 2'b00;
    endfunction

    // The current symbol lands in stream s; one more symbol of the slot is used.
    function automatic void take(int s);
        longint n;
        int     k;
        n = (switch_clock_cycles == 0) ? 64'd1 : longint'(switch_clock_cycles);
        k = int'(mode);
        m_ds[s]    = multiplexed_data;
        m_valid[s] = 1'b1;
        m_cnt      = m_cnt + 1;
        if (m_cnt >= n) begin
            m_cnt  = 0;
            m_slot = (m_slot + 1) % k;
        end
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
        m_err = 1'b0;
        if (mode != m_mode_q) begin
            m_locked = 1'b0;
            m_cnt    = 0;
            m_slot   = 0;
        end else if (!m_locked) begin
            if (symbol_en && frame_sync && mode != 2'b00) begin
                m_locked = 1'b1;
                m_cnt    = 0;
                m_slot   = 0;
                take(0);
            end
        end else if (symbol_en) begin
            if (frame_sync) begin
                m_err  = (m_slot != 0) || (m_cnt != 0);
                m_slot = 0;
                m_cnt  = 0;
            end
            take(m_slot);
        end
        m_mode_q = mode;
    endfunction

    function automatic logic [54:0] obs_vec();
        return {ds1_out, ds2_out, ds3_out, ds1_valid, ds2_valid, ds3_valid,
                slot, locked, sync_err};
    endfunction

    function automatic logic [54:0] exp_vec();
        return {m_ds[0], m_ds[1], m_ds[2], m_valid[0], m_valid[1], m_valid[2],
                2'(m_slot), m_locked, m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic en, input logic fs, input logic [DATA_W-1:0] d);
        symbol_en        = en;
        frame_sync       = fs;
        multiplexed_data = d;
        tick();
    endtask

    task automatic test_reset();
        rst                 = 1'b1;
        symbol_en           = 1'b0;
        frame_sync          = 1'b0;
        mode                = 2'b00;
        switch_clock_cycles = '0;
        multiplexed_data    = '0;
        model_reset();
        #1;
        n_cmp++;
        if (obs_vec() !== 55'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_init got %h expected 0", obs_vec());
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL reset_idle got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_three_streams();
        mode                = 2'b11;
        switch_clock_cycles = 32'd2;
        send(1'b0, 1'b0, '0);
        send(1'b0, 1'b0, '0);
        for (int i = 1; i <= 6; i++) begin
            send(1'b1, i == 1, 16'(i));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL three_streams sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (sync_err !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL three_streams_err sym %0d got %b expected 0", i, sync_err);
            end
        end
        send(1'b0, 1'b0, '0);
        n_cmp++;
        if ({ds1_out, ds2_out, ds3_out, slot, locked} !== {16'h0002, 16'h0004, 16'h0006, 2'd0, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL three_streams_final got %h/%h/%h slot %0d lock %b expected 0002/0004/0006 slot 0 lock 1",
                     ds1_out, ds2_out, ds3_out, slot, locked);
        end
    endtask

    task automatic test_two_streams_gaps();
        logic [DATA_W-1:0] syms [4];
        syms[0] = 16'hA000;
        syms[1] = 16'hB000;
        syms[2] = 16'hA001;
        syms[3] = 16'hB001;
        mode                = 2'b10;
        switch_clock_cycles = 32'd1;
        send(1'b0, 1'b0, '0);
        send(1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, i == 0, syms[i]);
            n_cmp++;
            if ({ds1_valid, ds2_valid, ds3_valid} !== ((i % 2 == 0) ? 3'b100 : 3'b010)) begin
                n_bad++;
                $display("[TB] FAIL two_streams_valid sym %0d got %b%b%b", i, ds1_valid, ds2_valid, ds3_valid);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL two_streams sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
            for (int g = 0; g < 1 + int'($urandom_range(2, 0)); g++) begin
                send(1'b0, 1'b0, 16'($urandom));
                n_cmp++;
                if ({ds1_valid, ds2_valid, ds3_valid} !== 3'b000 || obs_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("[TB] FAIL two_streams_gap got %h expected %h", obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_resync();
        mode                = 2'b11;
        switch_clock_cycles = 32'd3;
        send(1'b0, 1'b0, '0);
        send(1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, i == 0, 16'h1000 + 16'(i));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL resync_pre sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        send(1'b1, 1'b1, 16'hBEEF);
        n_cmp++;
        if ({sync_err, ds1_valid, ds1_out, slot} !== {1'b1, 1'b1, 16'hBEEF, 2'd0}) begin
            n_bad++;
            $display("[TB] FAIL resync_err got err %b v %b ds1 %h slot %0d expected 1 1 beef 0",
                     sync_err, ds1_valid, ds1_out, slot);
        end
        send(1'b0, 1'b0, '0);
        n_cmp++;
        if (sync_err !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL resync_pulse got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0, 16'h2000 + 16'(i));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL resync_post sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        send(1'b1, 1'b1, 16'h3000);
        n_cmp++;
        if ({sync_err, ds1_out} !== {1'b0, 16'h3000} || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL resync_aligned got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_mode_switch();
        mode = 2'b01;
        send(1'b1, 1'b0, 16'h4444);
        n_cmp++;
        if (locked !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL mode_switch_drop got lock %b, %h expected %h", locked, obs_vec(), exp_vec());
        end
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0, 16'($urandom));
            n_cmp++;
            if ({ds1_valid, ds2_valid, ds3_valid} !== 3'b000 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL mode_switch_nocap got %h expected %h", obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) begin
            send(1'b1, i == 0, 16'($urandom));
            n_cmp++;
            if ({ds1_valid, ds2_valid, ds3_valid} !== 3'b100 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL mode_switch_ds1 sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_slot_length();
        switch_clock_cycles = 32'd0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0, 16'h5000 + 16'(i));
            n_cmp++;
            if ({ds1_valid, slot} !== {1'b1, 2'd0} || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL zero_len sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        mode                = 2'b10;
        switch_clock_cycles = 32'd4;
        send(1'b0, 1'b0, '0);
        send(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, i == 0, 16'h6000 + 16'(i));
            n_cmp++;
            if (slot !== 2'd0 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL shrink_pre sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        switch_clock_cycles = 32'd2;
        send(1'b1, 1'b0, 16'h6003);
        n_cmp++;
        if ({ds1_valid, ds1_out, slot} !== {1'b1, 16'h6003, 2'd1} || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL shrink_advance got %h expected %h", obs_vec(), exp_vec());
        end
        switch_clock_cycles = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, i == 0, 16'h7000 + 16'(i));
            n_cmp++;
            if ({ds1_valid, slot} !== {1'b1, 2'd0} || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL long_slot sym %0d got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(63, 0) == 0) mode = 2'($urandom);
            if ($urandom_range(15, 0) == 0)
                switch_clock_cycles = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF
                                                                  : 32'($urandom_range(5, 0));
            send(1'($urandom), $urandom_range(9, 0) == 0, 16'($urandom));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL random cycle %0d got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_locked();
        mode                = 2'b11;
        switch_clock_cycles = 32'd2;
        send(1'b0, 1'b0, '0);
        send(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) send(1'b1, i == 0, 16'h8000 + 16'(i));
        n_cmp++;
        if (locked !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_prelock got %h expected %h", obs_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (obs_vec() !== 55'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_async got %h expected 0", obs_vec());
        end
        #1;
        rst = 1'b0;
        send(1'b0, 1'b0, '0);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_settle got %h expected %h", obs_vec(), exp_vec());
        end
        send(1'b1, 1'b1, 16'h9ABC);
        n_cmp++;
        if ({locked, ds1_valid, ds1_out} !== {1'b1, 1'b1, 16'h9ABC} || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_relock got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_three_streams();
        test_two_streams_gaps();
        test_resync();
        test_mode_switch();
        test_slot_length();
        test_random();
        test_reset_mid_locked();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
